// File: rtl/audio_pkg.sv
// Shared defaults and types for the codec ADC capture path.
package audio_pkg;

  localparam int unsigned AUDIO_SAMPLE_W   = 16;
  localparam int unsigned AUDIO_FIFO_DEPTH = 4;

  typedef logic [2*AUDIO_SAMPLE_W-1:0] audio_frame_t;

  typedef enum logic [2:0] {
    StIdle,
    StDlyL,
    StShfL,
    StWaitR,
    StDlyR,
    StShfR,
    StWaitL
  } cap_state_e;

endpackage

// File: rtl/audio_adc_capture_if.sv
// Ready/valid stereo frame port from the capture block to the record core.
interface audio_adc_capture_if
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W = AUDIO_SAMPLE_W
);
  logic [2*SAMPLE_W-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave (input data, input valid, output ready);
endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous frame FIFO with flush; head data reads as zero while empty.
module audio_sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ptr_t             wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot in the same cycle, so a push on full still lands.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/audio_adc_capture.sv
// I2S codec ADC capture: pin synchronisers, deserialiser FSM and frame FIFO.
// Define AUDIO_DROP_CNT_EN to build the saturating dropped-frame counter.
module audio_adc_capture
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = AUDIO_SAMPLE_W,
  parameter int unsigned FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_aud_bclk,
  input  logic                i_aud_adclrck,
  input  logic                i_aud_adcdat,
  audio_adc_capture_if.master aud_out,
  output logic                o_overflow,
  output logic [15:0]         o_drop_cnt
);
  localparam int unsigned CntW   = $clog2(SAMPLE_W);
  localparam int unsigned FrameW = 2 * SAMPLE_W;

  // Bit order in the sync stages: {dat, lrck, bclk}.
  logic [2:0] sync1_q, sync2_q;
  logic       bclk_prev_q, lrck_prev_q, enable_q;
  logic       bclk_rise, lrck_rise, lrck_fall, enable_rise, dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      sync1_q     <= {i_aud_adcdat, i_aud_adclrck, i_aud_bclk};
      sync2_q     <= sync1_q;
      bclk_prev_q <= sync2_q[0];
      lrck_prev_q <= sync2_q[1];
      enable_q    <= i_enable;
    end
  end

  assign bclk_rise   = sync2_q[0] & ~bclk_prev_q;
  assign lrck_fall   = lrck_prev_q & ~sync2_q[1];
  assign lrck_rise   = ~lrck_prev_q & sync2_q[1];
  assign enable_rise = i_enable & ~enable_q;
  assign dat         = sync2_q[2];

  cap_state_e          state_q, state_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] sr_l_q, sr_l_d, sr_r_next;
  logic [SAMPLE_W-2:0] sr_r_q, sr_r_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic                push_q, push_d, last_bit;

  // LRCK edges act on the cycle they are seen so the delay bit is the next BCLK rise.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_l_d    = sr_l_q;
    sr_r_d    = sr_r_q;
    frame_d   = frame_q;
    push_d    = 1'b0;
    sr_r_next = {sr_r_q, dat};
    last_bit  = (bit_cnt_q == CntW'(SAMPLE_W - 1));
    if (!i_enable) begin
      state_d = StIdle;
    end else if (lrck_fall) begin
      state_d = StDlyL;
    end else if (state_q == StIdle) begin
      state_d = StIdle;
    end else if (lrck_rise) begin
      state_d = (state_q == StWaitR) ? StDlyR : StWaitL;
    end else if (bclk_rise) begin
      unique case (state_q)
        StDlyL: begin
          state_d   = StShfL;
          bit_cnt_d = '0;
        end
        StShfL: begin
          sr_l_d    = {sr_l_q[SAMPLE_W-2:0], dat};
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (last_bit) state_d = StWaitR;
        end
        StDlyR: begin
          state_d   = StShfR;
          bit_cnt_d = '0;
        end
        StShfR: begin
          sr_r_d    = sr_r_next[SAMPLE_W-2:0];
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (last_bit) begin
            push_d  = 1'b1;
            frame_d = {sr_l_q, sr_r_next};
            state_d = StWaitL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      sr_l_q    <= '0;
      sr_r_q    <= '0;
      frame_q   <= '0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_l_q    <= sr_l_d;
      sr_r_q    <= sr_r_d;
      frame_q   <= frame_d;
      push_q    <= push_d;
    end
  end

  logic              fifo_full, fifo_empty, pop, drop, overflow_q, overflow_d;
  logic [FrameW-1:0] fifo_data;

  audio_sample_fifo #(
    .WIDTH (FrameW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .flush_i (~i_enable),
    .push_i  (push_q),
    .data_i  (frame_q),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop           = ~fifo_empty & aud_out.ready;
  assign drop          = i_enable & push_q & fifo_full & ~pop;
  assign aud_out.valid = ~fifo_empty;
  assign aud_out.data  = fifo_data;
  assign overflow_d    = enable_rise ? 1'b0 : (overflow_q | drop);
  assign o_overflow    = overflow_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

`ifdef AUDIO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (enable_rise)                       drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_audio_adc_capture.sv
// Bench for audio_adc_capture: I2S codec model, frame queue reference and beat scoreboard.
module tb_audio_adc_capture;
  import audio_pkg::*;

  localparam int unsigned Depth = AUDIO_FIFO_DEPTH;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic        bclk   = 1'b1;
  logic        lrck   = 1'b1;
  logic        adcdat = 1'b0;
  logic        overflow;
  logic [15:0] drop_cnt;

  audio_adc_capture_if #(.SAMPLE_W(AUDIO_SAMPLE_W)) aud ();

  audio_adc_capture #(
    .SAMPLE_W   (AUDIO_SAMPLE_W),
    .FIFO_DEPTH (Depth)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_aud_bclk    (bclk),
    .i_aud_adclrck (lrck),
    .i_aud_adcdat  (adcdat),
    .aud_out       (aud),
    .o_overflow    (overflow),
    .o_drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           beats    = 0;
  int           valid_cycles = 0;
  int           exp_drops = 0;
  bit           exp_ovf   = 1'b0;
  bit           rand_done = 1'b0;
  audio_frame_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_drop_cnt();
`ifdef AUDIO_DROP_CNT_EN
    return (exp_drops > 65535) ? 32'h0000FFFF : 32'(exp_drops);
`else
    return 32'h0;
`endif
  endfunction

  // Scoreboard: every accepted beat must match the oldest expected frame.
  logic         held = 1'b0;
  audio_frame_t held_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (aud.valid) valid_cycles++;
      if (held && aud.valid) check("hold_stable", aud.data, held_data);
      if (aud.valid && aud.ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_unexpected: got %h expected no beat", aud.data);
        end else begin
          check("beat", aud.data, exp_q.pop_front());
        end
      end
      held      = aud.valid && !aud.ready;
      held_data = aud.data;
    end
  end

  task automatic set_enable(input logic v);
    if (v && !enable) begin
      exp_drops = 0;
      exp_ovf   = 1'b0;
    end
    if (!v) exp_q.delete();
    enable = v;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 aud.ready = v;
    @(negedge clk);
  endtask

  // 32-bit I2S slots, BCLK = clk/8. Modes: 0 plain, 1 pop on the push cycle of a
  // full FIFO, 2 enable mid right slot, 3 disable mid left shift, 4 reset mid left.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int mode);
    bit clean;
    clean = enable && rst_n;
    for (int i = 0; i < 32; i++) begin
      bclk   = 1'b0;
      lrck   = 1'b0;
      adcdat = (i >= 1 && i <= 16) ? l[16-i] : 1'($urandom);
      if (mode == 3 && i == 5) begin
        set_enable(1'b0);
        clean = 1'b0;
        @(posedge clk);
        #1;
        check("t4_valid_after_disable", 32'(aud.valid), 32'h0);
        check("t4_ovf_sticky", 32'(overflow), 32'(exp_ovf));
      end
      if (mode == 4 && i == 8) begin
        rst_n = 1'b0;
        #3;
        check("t6_rst_valid", 32'(aud.valid), 32'h0);
        check("t6_rst_data", aud.data, 32'h0);
        check("t6_rst_ovf", 32'(overflow), 32'h0);
        check("t6_rst_drop", 32'(drop_cnt), 32'h0);
        exp_q.delete();
        exp_drops = 0;
        exp_ovf   = 1'b0;
        clean     = 1'b0;
      end
      if (mode == 4 && i == 12) rst_n = 1'b1;
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    for (int i = 0; i < 32; i++) begin
      bclk   = 1'b0;
      lrck   = 1'b1;
      adcdat = (i >= 1 && i <= 16) ? r[16-i] : 1'($urandom);
      if (i == 0 && clean && enable && rst_n) begin
        if (exp_q.size() < Depth || mode == 1) begin
          exp_q.push_back({l, r});
        end else begin
          exp_drops++;
          exp_ovf = 1'b1;
        end
      end
      if (mode == 2 && i == 5) set_enable(1'b1);
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      if (mode == 1 && i == 16) begin
        // Last right bit lands in the FIFO four clock edges later; pop exactly then.
        repeat (3) @(posedge clk);
        #1 aud.ready = 1'b1;
        @(posedge clk);
        #1 aud.ready = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'h0);
    repeat (2) @(negedge clk);
    check({name, "_valid"}, 32'(aud.valid), 32'h0);
  endtask

  initial begin
    int b0;
    int v0;
    aud.ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(aud.valid), 32'h0);
    check("rst_data", aud.data, 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single frame, consumer always ready
    set_enable(1'b1);
    set_ready(1'b1);
    b0 = beats;
    v0 = valid_cycles;
    send_frame(16'hA5A5, 16'h5A5A, 0);
    repeat (20) @(negedge clk);
    check("t1_beats", 32'(beats - b0), 32'd1);
    check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);

    // 2: overflow with consumer stalled
    set_ready(1'b0);
    for (int k = 1; k <= 5; k++) send_frame(16'h1000 + 16'(k), 16'(k), 0);
    check("t2_ovf", 32'(overflow), 32'h1);
    check("t2_drop", 32'(drop_cnt), exp_drop_cnt());
    check("t2_head", aud.data, 32'h1001_0001);
    set_ready(1'b1);
    wait_drain("t2_drain");

    // 4: disable during left shift with two frames queued
    set_ready(1'b0);
    send_frame(16'(1'($urandom) ? 16'h1111 : 16'h2222), 16'($urandom), 0);
    send_frame(16'($urandom), 16'($urandom), 0);
    send_frame(16'hDEAD, 16'hBEEF, 3);
    set_enable(1'b1);
    repeat (3) @(negedge clk);
    check("t4_ovf_cleared", 32'(overflow), 32'h0);
    check("t4_drop_cleared", 32'(drop_cnt), exp_drop_cnt());
    set_ready(1'b1);
    send_frame(16'h4444, 16'h0404, 0);
    wait_drain("t4_drain");

    // 3: enable arrives mid right slot
    set_enable(1'b0);
    repeat (4) @(negedge clk);
    b0 = beats;
    send_frame(16'h3333, 16'h0303, 2);
    send_frame(16'h3C3C, 16'hC3C3, 0);
    wait_drain("t3_drain");
    check("t3_beats", 32'(beats - b0), 32'd1);

    // 5: full FIFO, push and pop in the same cycle
    set_ready(1'b0);
    for (int k = 1; k <= 4; k++) send_frame(16'h5000 + 16'(k), 16'h0500 + 16'(k), 0);
    send_frame(16'h5005, 16'h0505, 1);
    check("t5_ovf", 32'(overflow), 32'h0);
    check("t5_drop", 32'(drop_cnt), exp_drop_cnt());
    set_ready(1'b1);
    wait_drain("t5_drain");

    // 6: asynchronous reset mid frame with a full FIFO and overflow set
    set_ready(1'b0);
    for (int k = 1; k <= 5; k++) send_frame(16'h6000 + 16'(k), 16'($urandom), 0);
    check("t6_ovf_pre", 32'(overflow), 32'h1);
    send_frame(16'h6666, 16'h0606, 4);
    set_ready(1'b1);
    send_frame(16'h6A6A, 16'hA6A6, 0);
    wait_drain("t6_drain");

    // Random data with a randomly stalling consumer
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send_frame(16'($urandom), 16'($urandom), 0);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 aud.ready = 1'($urandom);
        end
      end
    join
    set_ready(1'b1);
    wait_drain("rand_drain");
    check("final_ovf", 32'(overflow), 32'(exp_ovf));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: got still running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule
